// File: rtl/vision_frame_seq.sv
// vision_frame_seq: frame-level sequencer for the connected-component vision core.
// Fetches each row from line memory one word at a time, hands the full row to the core,
// steps through ROWS rows and latches the centroid results on core_stop.
// Optional watchdog abort: define VISION_SEQ_WDOG_EN.
module vision_frame_seq #(
  parameter int unsigned LINE_W      = 320,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned ROWS        = 240,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WDOG_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              busy,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              core_clr_n,
  output logic [LINE_W-1:0] core_line,
  output logic              core_start,
  input  logic              core_data_update,
  input  logic              core_stop,
  input  logic [16:0]       core_four,
  input  logic [16:0]       core_o,
  input  logic [16:0]       core_six,
  output logic [16:0]       res_four,
  output logic [16:0]       res_o,
  output logic [16:0]       res_six,
  output logic              result_valid,
  output logic              err
);

  localparam int unsigned WORDS     = LINE_W / WORD_W;
  localparam int unsigned WORD_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    StIdle, StClear, StFetch, StKick, StWait, StResult, StAbort
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          row_q, row_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                pend_q, pend_d;
  logic                clr_cnt_q, clr_cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [16:0]         four_q, four_d, o_q, o_d, six_q, six_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                core_clr_n_q, core_clr_n_d;
  logic                issue;
  logic                wdog_hit;

`ifdef VISION_SEQ_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
  logic              wdog_run;
  logic              wdog_kick;

  assign wdog_run  = (state_q == StFetch) || (state_q == StWait);
  assign wdog_kick = rd_valid || core_data_update || core_stop;
  assign wdog_hit  = wdog_run && !wdog_kick && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
  assign err       = err_q;

  // Watchdog: counts idle cycles in FETCH/WAIT, restarts on any memory or core event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= wdog_hit;
      if (wdog_run && !wdog_kick && !wdog_hit) begin
        wdog_q <= wdog_q + 1'b1;
      end else begin
        wdog_q <= '0;
      end
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      word_q       <= '0;
      pend_q       <= 1'b0;
      clr_cnt_q    <= 1'b0;
      line_q       <= '0;
      four_q       <= '0;
      o_q          <= '0;
      six_q        <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      core_clr_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      word_q       <= word_d;
      pend_q       <= pend_d;
      clr_cnt_q    <= clr_cnt_d;
      line_q       <= line_d;
      four_q       <= four_d;
      o_q          <= o_d;
      six_q        <= six_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      core_clr_n_q <= core_clr_n_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    word_d    = word_q;
    pend_d    = pend_q;
    clr_cnt_d = 1'b0;
    line_d    = line_q;
    four_d    = four_q;
    o_d       = o_q;
    six_d     = six_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    issue     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_start) state_d = StClear;
      end
      StClear: begin
        clr_cnt_d = 1'b1;
        if (clr_cnt_q) begin
          state_d = StFetch;
          row_d   = '0;
          word_d  = '0;
          pend_d  = 1'b0;
        end
      end
      StFetch: begin
        if (!pend_q) begin
          issue = 1'b1;
        end else if (rd_valid) begin
          line_d[word_q*WORD_W +: WORD_W] = rd_data;
          pend_d = 1'b0;
          if (word_q == WORD_BITS'(WORDS - 1)) begin
            state_d = StKick;
          end else begin
            // Issue the next word in the same cycle to keep one read per (1 + latency).
            word_d = word_q + 1'b1;
            issue  = 1'b1;
          end
        end
      end
      StKick: begin
        state_d = StWait;
      end
      StWait: begin
        if (core_stop) begin
          four_d  = core_four;
          o_d     = core_o;
          six_d   = core_six;
          state_d = StResult;
        end else if (core_data_update) begin
          // Saturate on a protocol violation so the last row is simply refetched.
          if (row_q != 8'(ROWS - 1)) row_d = row_q + 1'b1;
          word_d  = '0;
          state_d = StFetch;
        end
      end
      StResult: begin
        state_d = StIdle;
      end
      StAbort: begin
        clr_cnt_d = 1'b1;
        if (clr_cnt_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (wdog_hit) begin
      state_d = StAbort;
      issue   = 1'b0;
      pend_d  = 1'b0;
    end

    if (issue) begin
      rd_req_d  = 1'b1;
      pend_d    = 1'b1;
      rd_addr_d = ADDR_W'(row_q * WORDS + word_d);
    end

    // Registered clear tracks the state being entered, so it is low exactly while in it.
    core_clr_n_d = !((state_d == StClear) || (state_d == StAbort));
  end

  // State-decoded outputs.
  always_comb begin
    busy         = 1'b0;
    core_start   = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      StClear, StFetch, StWait: busy = 1'b1;
      StKick: begin
        busy       = 1'b1;
        core_start = 1'b1;
      end
      StResult: result_valid = 1'b1;
      default: ;
    endcase
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign core_clr_n = core_clr_n_q;
  assign core_line  = line_q;
  assign res_four   = four_q;
  assign res_o      = o_q;
  assign res_six    = six_q;

endmodule
